// File: rtl/pipe_pkg.sv
// Shared constants and types for pipeline stage boundary registers.
package pipe_pkg;

  localparam int DATA_W_DEF = 72;
  localparam int PC_W_DEF   = 32;
  localparam int EXC_W_DEF  = 4;

  // All-ones exception code marks a clean beat.
  localparam logic [EXC_W_DEF-1:0] EXC_NONE = 4'b1111;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake, payload and exception-record signals of a pipeline stage boundary.
interface pipe_stage_buf_if #(
  parameter int DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int PC_W   = pipe_pkg::PC_W_DEF,
  parameter int EXC_W  = pipe_pkg::EXC_W_DEF
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [PC_W-1:0]   i_pc;
  logic [EXC_W-1:0]  i_exc_code;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_flush_upstream;
  logic              o_exc_valid;
  logic [EXC_W-1:0]  o_exc_code;
  logic [PC_W-1:0]   o_exc_pc;
  logic              i_exc_ack;

  // Stage side.
  modport slave (
    input  i_valid, i_data, i_pc, i_exc_code, i_flush, i_ready, i_exc_ack,
    output o_ready, o_valid, o_data, o_flush_upstream,
           o_exc_valid, o_exc_code, o_exc_pc
  );

  // Surrounding pipeline side.
  modport master (
    output i_valid, i_data, i_pc, i_exc_code, i_flush, i_ready, i_exc_ack,
    input  o_ready, o_valid, o_data, o_flush_upstream,
           o_exc_valid, o_exc_code, o_exc_pc
  );
endinterface

// File: rtl/pipe_stage_buf_skid_buf.sv
// Two-entry skid buffer: main entry drives the output, skid entry holds the
// next-oldest beat. Ready is decoded from occupancy only, so no combinational
// path exists from downstream ready to upstream ready.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  occ_e         occ, occ_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         acc, emit;
  logic         ld_main_in, ld_main_skid, ld_skid_in;

  assign o_ready = (occ != OCC_TWO);
  assign o_valid = (occ != OCC_EMPTY);
  assign o_data  = main_q;
  assign acc     = i_valid && o_ready;
  assign emit    = o_valid && i_ready;

  // Occupancy state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) occ <= OCC_EMPTY;
    else       occ <= occ_nxt;
  end

  // Next occupancy and entry load selects; flush empties and suppresses loads.
  always_comb begin
    occ_nxt      = occ;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    case (occ)
      OCC_EMPTY: begin
        if (acc) begin
          occ_nxt    = OCC_ONE;
          ld_main_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (acc && !emit) begin
          occ_nxt    = OCC_TWO;
          ld_skid_in = 1'b1;
        end else if (emit && !acc) begin
          occ_nxt = OCC_EMPTY;
        end else if (acc && emit) begin
          ld_main_in = 1'b1;
        end
      end
      OCC_TWO: begin
        if (emit) begin
          occ_nxt      = OCC_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
    if (i_flush) begin
      occ_nxt      = OCC_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
    end
  end

  // Payload entries load only on accept or skid-to-main shift; emit leaves them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= i_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid_in)        skid_q <= i_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage boundary register: skid buffer for the payload plus a
// sticky first-fault record and a same-cycle upstream flush request.
module pipe_stage_buf #(
  parameter int               DATA_W   = pipe_pkg::DATA_W_DEF,
  parameter int               PC_W     = pipe_pkg::PC_W_DEF,
  parameter int               EXC_W    = pipe_pkg::EXC_W_DEF,
  parameter logic [EXC_W-1:0] EXC_NONE = pipe_pkg::EXC_NONE
) (
  input logic              i_clk,
  input logic              i_rst,
  pipe_stage_buf_if.slave  bus
);

  logic             skid_rdy;
  logic             rdy;
  logic             beat_clean;
  logic             fault_acc;
  logic             exc_valid_q;
  logic [EXC_W-1:0] exc_code_q;
  logic [PC_W-1:0]  exc_pc_q;

  // A pending record blocks intake so only the first fault is ever captured.
  assign rdy        = skid_rdy && !exc_valid_q;
  assign beat_clean = (bus.i_exc_code == EXC_NONE);
  // A flushed beat is discarded outright, even if it faults.
  assign fault_acc  = bus.i_valid && rdy && !bus.i_flush && !beat_clean;

  assign bus.o_ready          = rdy;
  assign bus.o_flush_upstream = fault_acc;
  assign bus.o_exc_valid      = exc_valid_q;
  assign bus.o_exc_code       = exc_code_q;
  assign bus.o_exc_pc         = exc_pc_q;

  skid_buf #(.W(DATA_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (bus.i_valid && rdy && beat_clean && !bus.i_flush),
    .o_ready (skid_rdy),
    .i_data  (bus.i_data),
    .i_flush (bus.i_flush),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (bus.o_data)
  );

  // Sticky exception record: load on first fault, clear valid on ack, keep code/pc.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      exc_pc_q    <= '0;
    end else if (fault_acc) begin
      exc_valid_q <= 1'b1;
      exc_code_q  <= bus.i_exc_code;
      exc_pc_q    <= bus.i_pc;
    end else if (bus.i_exc_ack) begin
      exc_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: table-driven vectors plus hand sequences, with a
// queue scoreboard that predicts every output each cycle.
module tb_pipe_stage_buf;
  localparam int DW = 72;
  localparam int PW = 32;
  localparam int EW = 4;
  localparam logic [EW-1:0] NONE = 4'hF;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  pipe_stage_buf_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) bus ();

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [PW-1:0] pc;
    logic [EW-1:0] code;
    logic          fl;
    logic          rdy;
    logic          ack;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic          e_fu;
    logic          e_xv;
    logic [EW-1:0] e_code;
    logic [PW-1:0] e_pc;
  } vec_t;

  vec_t          tbl[$];
  int            n_vec = 0;
  int            n_err = 0;

  // Reference model: in-order queue of buffered beats plus the exception record.
  logic [DW-1:0] mq[$];
  logic          m_xv;
  logic [EW-1:0] m_code;
  logic [PW-1:0] m_pc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_xv   = 1'b0;
    m_code = NONE;
    m_pc   = '0;
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                     input logic [EW-1:0] code, input logic rdy, input logic ack,
                     input logic e_rdy, input logic e_vld, input logic [DW-1:0] e_data,
                     input logic e_fu, input logic e_xv, input logic [EW-1:0] e_code,
                     input logic [PW-1:0] e_pc);
    vec_t v;
    v.iv = iv; v.d = d; v.pc = pc; v.code = code; v.fl = 1'b0; v.rdy = rdy; v.ack = ack;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_fu = e_fu;
    v.e_xv = e_xv; v.e_code = e_code; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  // Drive one cycle after the falling edge, check outputs against the model,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                      input logic [EW-1:0] code, input logic fl, input logic rdy,
                      input logic ack);
    logic e_rdy, e_vld, e_fu, emit, acc;
    @(negedge i_clk);
    bus.i_valid = iv; bus.i_data = d; bus.i_pc = pc; bus.i_exc_code = code;
    bus.i_flush = fl; bus.i_ready = rdy; bus.i_exc_ack = ack;
    #1;
    e_rdy = (mq.size() < 2) && !m_xv;
    e_vld = (mq.size() > 0);
    e_fu  = iv && e_rdy && !fl && (code != NONE);
    chk("o_ready", 128'(bus.o_ready), 128'(e_rdy));
    chk("o_valid", 128'(bus.o_valid), 128'(e_vld));
    if (e_vld) chk("o_data", 128'(bus.o_data), 128'(mq[0]));
    chk("o_flush_upstream", 128'(bus.o_flush_upstream), 128'(e_fu));
    chk("o_exc_valid", 128'(bus.o_exc_valid), 128'(m_xv));
    chk("o_exc_code", 128'(bus.o_exc_code), 128'(m_code));
    chk("o_exc_pc", 128'(bus.o_exc_pc), 128'(m_pc));
    emit = e_vld && rdy;
    acc  = iv && e_rdy && !fl && (code == NONE);
    if (emit) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (acc) mq.push_back(d);
    if (e_fu) begin
      m_xv = 1'b1; m_code = code; m_pc = pc;
    end else if (ack) begin
      m_xv = 1'b0;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, NONE, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [95:0] r;
    bus.i_valid = 0; bus.i_data = '0; bus.i_pc = '0; bus.i_exc_code = NONE;
    bus.i_flush = 0; bus.i_ready = 0; bus.i_exc_ack = 0;
    model_reset();

    // Reset values.
    @(negedge i_clk); #1;
    chk("rst o_valid", 128'(bus.o_valid), 128'(0));
    chk("rst o_ready", 128'(bus.o_ready), 128'(1));
    chk("rst o_data", 128'(bus.o_data), 128'(0));
    chk("rst o_exc_valid", 128'(bus.o_exc_valid), 128'(0));
    chk("rst o_exc_code", 128'(bus.o_exc_code), 128'(NONE));
    chk("rst o_exc_pc", 128'(bus.o_exc_pc), 128'(0));
    chk("rst o_flush_upstream", 128'(bus.o_flush_upstream), 128'(0));
    i_rst = 1'b0;

    // Streaming 1..8, then backpressure, then fault capture / second fault / ack.
    add(1, 72'h1, 0, NONE, 1, 0, 1, 0, 0,  0, 0, NONE, 0);
    for (int i = 2; i <= 8; i++)
      add(1, DW'(i), 0, NONE, 1, 0, 1, 1, DW'(i - 1), 0, 0, NONE, 0);
    add(0, 0, 0, NONE, 1, 0, 1, 1, 72'h8, 0, 0, NONE, 0);
    add(0, 0, 0, NONE, 1, 0, 1, 0, 0,     0, 0, NONE, 0);
    add(1, 72'h11, 0, NONE, 1, 0, 1, 0, 0,      0, 0, NONE, 0);
    add(1, 72'h12, 0, NONE, 0, 0, 1, 1, 72'h11, 0, 0, NONE, 0);
    add(1, 72'h13, 0, NONE, 0, 0, 0, 1, 72'h11, 0, 0, NONE, 0);
    add(1, 72'h13, 0, NONE, 0, 0, 0, 1, 72'h11, 0, 0, NONE, 0);
    add(1, 72'h13, 0, NONE, 1, 0, 0, 1, 72'h11, 0, 0, NONE, 0);
    add(1, 72'h13, 0, NONE, 1, 0, 1, 1, 72'h12, 0, 0, NONE, 0);
    add(0, 0,      0, NONE, 1, 0, 1, 1, 72'h13, 0, 0, NONE, 0);
    add(0, 0,      0, NONE, 1, 0, 1, 0, 0,      0, 0, NONE, 0);
    add(1, 72'hAA, 32'h100, 4'd2, 1, 0, 1, 0, 0, 1, 0, NONE, 0);
    add(1, 72'hBB, 32'h104, 4'd3, 1, 0, 0, 0, 0, 0, 1, 4'd2, 32'h100);
    add(0, 0, 0, NONE, 1, 1, 0, 0, 0, 0, 1, 4'd2, 32'h100);
    add(0, 0, 0, NONE, 1, 0, 1, 0, 0, 0, 0, 4'd2, 32'h100);

    foreach (tbl[k]) begin
      step(tbl[k].iv, tbl[k].d, tbl[k].pc, tbl[k].code, tbl[k].fl, tbl[k].rdy, tbl[k].ack);
      chk($sformatf("tbl[%0d] o_ready", k), 128'(bus.o_ready), 128'(tbl[k].e_rdy));
      chk($sformatf("tbl[%0d] o_valid", k), 128'(bus.o_valid), 128'(tbl[k].e_vld));
      if (tbl[k].e_vld)
        chk($sformatf("tbl[%0d] o_data", k), 128'(bus.o_data), 128'(tbl[k].e_data));
      chk($sformatf("tbl[%0d] flush_up", k), 128'(bus.o_flush_upstream), 128'(tbl[k].e_fu));
      chk($sformatf("tbl[%0d] exc_valid", k), 128'(bus.o_exc_valid), 128'(tbl[k].e_xv));
      chk($sformatf("tbl[%0d] exc_code", k), 128'(bus.o_exc_code), 128'(tbl[k].e_code));
      chk($sformatf("tbl[%0d] exc_pc", k), 128'(bus.o_exc_pc), 128'(tbl[k].e_pc));
    end

    // Flush while full with a faulting beat offered: no capture, no upstream flush.
    step(1, 72'h21, 0, NONE, 0, 0, 0);
    step(1, 72'h22, 0, NONE, 0, 0, 0);
    step(1, 72'h23, 32'h200, 4'd5, 1, 0, 0);
    chk("flush2 flush_up", 128'(bus.o_flush_upstream), 128'(0));
    idle(0);
    chk("flush2 o_valid", 128'(bus.o_valid), 128'(0));
    chk("flush2 exc_valid", 128'(bus.o_exc_valid), 128'(0));
    chk("flush2 o_ready", 128'(bus.o_ready), 128'(1));

    // Flush together with emit from a full buffer: emit completes, ends empty.
    step(1, 72'h31, 0, NONE, 0, 0, 0);
    step(1, 72'h32, 0, NONE, 0, 0, 0);
    step(0, 0, 0, NONE, 1, 1, 0);
    chk("flush+emit o_data", 128'(bus.o_data), 128'(72'h31));
    idle(1);
    chk("flush+emit o_valid", 128'(bus.o_valid), 128'(0));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      r = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), r[DW-1:0], $urandom,
           ($urandom_range(0, 7) == 0) ? EW'($urandom_range(0, 14)) : NONE,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) == 0));
    end

    // Async reset while full: outputs clear before the next rising edge.
    step(0, 0, 0, NONE, 1, 1, 1);
    idle(0);
    step(1, 72'h41, 0, NONE, 0, 0, 0);
    step(1, 72'h42, 0, NONE, 0, 0, 0);
    @(negedge i_clk);
    bus.i_valid = 0;
    #2 i_rst = 1'b1;
    #1;
    chk("arst o_valid", 128'(bus.o_valid), 128'(0));
    chk("arst o_ready", 128'(bus.o_ready), 128'(1));
    chk("arst o_data", 128'(bus.o_data), 128'(0));
    chk("arst exc_valid", 128'(bus.o_exc_valid), 128'(0));
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1, 72'h51, 0, NONE, 0, 1, 0);
    idle(1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register replacing the fixed-field execute/memory boundary register. It carries an opaque payload through a two-entry skid buffer with valid/ready handshaking on both sides, so stalls propagate without combinational ready paths. It captures the first faulting beat's exception code and PC into a sticky record that is held until acknowledged, and raises a same-cycle upstream flush. It is instantiated at the EX/MEM boundary and is reusable at any other stage boundary.

## Interface
- DATA_W, 72: payload width (rd, ALU result, store data, control bits packed by the instantiating stage)
- PC_W, 32: width of the PC carried for exception capture
- EXC_W, 4: exception code width
- EXC_NONE, 4'b1111: code value meaning "no exception"

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream beat valid
- o_ready  out  1  stage can accept a beat this cycle
- i_data  in  DATA_W  upstream payload
- i_pc  in  PC_W  PC of upstream beat
- i_exc_code  in  EXC_W  exception code of upstream beat
- i_flush  in  1  synchronous flush of buffered beats
- o_valid  out  1  downstream beat valid
- i_ready  in  1  downstream accepts
- o_data  out  DATA_W  downstream payload
- o_flush_upstream  out  1  combinational flush request to earlier stages (IF/ID, ID/EX)
- o_exc_valid  out  1  sticky exception record present
- o_exc_code  out  EXC_W  captured code
- o_exc_pc  out  PC_W  captured PC
- i_exc_ack  in  1  clears the exception record

## Operation
- Accept when i_valid && o_ready. Emit when o_valid && i_ready.
- Occupancy FSM: EMPTY, ONE, TWO. Entry order: the main entry drives o_data and the skid entry holds the second-oldest beat.
- EMPTY: accept → ONE.
- ONE: accept without emit → TWO. Emit without accept → EMPTY. Both → ONE, with the new beat replacing main.
- TWO: emit → ONE, with skid moving to main. No accept is possible in TWO.
- o_valid = (occ != EMPTY).
- o_ready = (occ != TWO) && !o_exc_valid. It is decoded from registers only and has no dependence on i_ready.
- Faulting beat: an accepted beat with i_exc_code != EXC_NONE.
  - It is not written into the buffer; occupancy changes only by any emit.
  - o_flush_upstream is asserted that same cycle.
  - The record (code, PC) is loaded and o_exc_valid is set next edge.
  - Only the first fault is captured, because o_ready is low while a record is pending.
- Older buffered beats continue to drain downstream while a record is pending.
- i_exc_ack clears o_exc_valid next edge. o_exc_code and o_exc_pc hold their last values.
- i_flush: occupancy → EMPTY next edge and any same-cycle input beat is discarded. If that beat faults, it is not captured and o_flush_upstream is not asserted. i_flush does not touch the exception record.

## Timing
- Reset values: occ = EMPTY, o_valid = 0, o_ready = 1, o_data = 0, o_exc_valid = 0, o_exc_code = EXC_NONE, o_exc_pc = 0. o_flush_upstream = 0 while no beat is offered.
- Reset asserted mid-operation clears all state immediately; buffered beats are lost.
- Latency: 1 cycle from accept to o_valid when EMPTY.
- Throughput: 1 beat/cycle with i_ready held high.
- Downstream stall: after i_ready drops, at most one more beat is accepted (into skid). o_ready falls the following cycle.
- Simultaneous events:
  - flush + emit: the emit completes and occupancy still ends EMPTY.
  - ack + pending record: o_ready rises the cycle after ack.
  - reset dominates everything.
- Data registers load only on accept or shift. They are not cleared on emit; only o_valid qualifies o_data.

## Structure
- Shared package pipe_pkg holds the EXC_NONE constant, the occupancy encoding (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2) and the default widths.
- Sub-module skid_buf (parameter W): the two-entry buffer plus occupancy FSM with valid/ready on both sides.
- pipe_stage_buf wraps skid_buf and adds:
  - the fault filter on the input side;
  - the exception record registers;
  - the o_ready gating by o_exc_valid;
  - the flush handling.

## Test plan
- Streaming: 8 beats with data 0x1..0x8 and i_ready = 1 → o_data shows 0x1..0x8 on consecutive cycles, 1-cycle latency, no bubbles.
- Backpressure: drop i_ready for 3 cycles mid-stream → exactly one extra beat absorbed, o_ready low for the stall, no loss or reorder after resume.
- Fault capture: beat with pc = 0x100 and exc = 4'd2 → o_flush_upstream high that cycle; next cycle o_exc_valid = 1, code = 2, pc = 0x100; the beat never appears on o_valid.
- Second fault blocked: faults at 0x100 then 0x104 → record stays 0x100. After i_exc_ack, o_exc_valid = 0 and o_ready = 1 on the following cycle.
- Flush in TWO: with the buffer full, i_flush while a faulting beat is offered → occupancy EMPTY, o_valid = 0, no capture, o_flush_upstream = 0.
- Async reset: assert i_rst between clock edges while in TWO → o_valid = 0 and o_ready = 1 before the next edge.
